// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop bits.
// Ports: clk/reset_n, data/valid/ready word handshake, parity_en/parity_odd, tx line, busy.

// Serial parity primitive: clr loads odd, we folds din into the running parity.
// Cleared only by its own strobe, so it carries no system reset.
module parity_serial_calculator (
   input  logic clk,
   input  logic clr,
   input  logic odd,
   input  logic we,
   input  logic din,
   output logic parity
);
   logic r_par;

   always_ff @(posedge clk) begin
      if (clr)
         r_par <= odd;
      else if (we)
         r_par <= r_par ^ din;
   end

   assign parity = r_par;
endmodule

module uart_tx_frame_sequencer #(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic                 tx,
   output logic                 busy
);
   localparam int TW = $clog2(CLK_DIV);
   localparam int BW = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic [TW-1:0]        r_tmr;
   logic [TW-1:0]        w_tmr_nx;
   logic [BW-1:0]        r_bit;
   logic [BW-1:0]        w_bit_nx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nx;
   logic                 r_par_en;
   logic                 w_par_en_nx;
   logic                 r_tx;
   logic                 w_tx_nx;
   logic                 w_xfer;
   logic                 w_bit_end;
   logic                 w_clr;
   logic                 w_we;
   logic                 w_par;

   assign w_xfer    = valid && (r_state == S_IDLE);
   assign w_bit_end = (r_tmr == TW'(CLK_DIV - 1));

   // Data bits are folded in on the first cycle of each bit, so the
   // parity result is settled well before the PARITY slot begins.
   parity_serial_calculator u_par (
      .clk    (clk),
      .clr    (w_clr),
      .odd    (parity_odd),
      .we     (w_we),
      .din    (r_shift[0]),
      .parity (w_par)
   );

   always_comb begin
      w_state_nx  = r_state;
      w_tmr_nx    = w_bit_end ? '0 : r_tmr + 1'b1;
      w_bit_nx    = r_bit;
      w_shift_nx  = r_shift;
      w_par_en_nx = r_par_en;
      w_clr       = 1'b0;
      w_we        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_tmr_nx = '0;
            if (w_xfer) begin
               w_state_nx  = S_START;
               w_shift_nx  = data;
               w_par_en_nx = parity_en;
               w_clr       = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end)
               w_state_nx = S_DATA;
         end
         S_DATA: begin
            w_we = (r_tmr == '0);
            if (w_bit_end) begin
               if (r_bit == BW'(DATA_BITS - 1))
                  w_state_nx = r_par_en ? S_PARITY : S_STOP;
               else begin
                  w_bit_nx   = r_bit + 1'b1;
                  w_shift_nx = r_shift >> 1;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end)
               w_state_nx = S_STOP;
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_bit == BW'(STOP_BITS - 1))
                  w_state_nx = S_IDLE;
               else
                  w_bit_nx = r_bit + 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (w_state_nx != r_state) begin
         w_tmr_nx = '0;
         w_bit_nx = '0;
      end

      // tx is registered: load the level belonging to the next state.
      unique case (w_state_nx)
         S_START:  w_tx_nx = 1'b0;
         S_DATA:   w_tx_nx = w_shift_nx[0];
         S_PARITY: w_tx_nx = w_par;
         default:  w_tx_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_tmr    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_par_en <= 1'b0;
         r_tx     <= 1'b1;
      end else begin
         r_state  <= w_state_nx;
         r_tmr    <= w_tmr_nx;
         r_bit    <= w_bit_nx;
         r_shift  <= w_shift_nx;
         r_par_en <= w_par_en_nx;
         r_tx     <= w_tx_nx;
      end
   end

   assign tx    = r_tx;
   assign ready = (r_state == S_IDLE);
   assign busy  = !ready;
endmodule

// File: doc/uart_tx_frame_sequencer.md
Name: uart_tx_frame_sequencer

Overview:
- Serial transmit frame controller that sequences the team's serial parity calculator primitive (parity_serial_calculator) to emit an asynchronous serial frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Accepts one parallel word per frame over a valid/ready handshake.
- Owns the bit timing, the frame state machine, and the clear/write strobes of the embedded parity calculator.
- Sits between the UART register block and the TX pin.

Parameters:
CLK_DIV, 16, clock cycles per serial bit (>= 2)
DATA_BITS, 8, data bits per frame (5..9)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
data  input  DATA_BITS  word to transmit
valid  input  1  data/parity_en/parity_odd valid
ready  output  1  block can accept a word (high only in IDLE)
parity_en  input  1  append parity bit to frame
parity_odd  input  1  1 = odd parity, 0 = even parity
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (reset_n low, async): state IDLE, tx=1, ready=1, busy=0, counters zero, shift register zero. Reset mid-frame aborts the frame immediately; no partial bits are resumed.
- Handshake: transfer when valid && ready in the same cycle. data, parity_en and parity_odd are latched at transfer and held internally for the whole frame. Input changes after transfer have no effect. valid while busy is ignored and is not queued.
- States:
  - IDLE: tx=1. On transfer, go to START and pulse the calculator's reset with odd=latched parity_odd, so its output initializes to parity_odd.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx = current LSB of the shift register for CLK_DIV cycles per bit, for DATA_BITS bits. In the first cycle of each bit, drive the calculator with we=1 and din=that bit. After the last bit, go to PARITY if parity_en, else STOP.
  - PARITY: tx = calculator parity output, held CLK_DIV cycles. Result: even mode makes the ones count of data+parity even; odd mode makes it odd.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then go to IDLE.
- Timing:
  - tx is registered. Transfer in cycle N gives tx=0 from cycle N+1.
  - Frame length = (1 + DATA_BITS + parity_en + STOP_BITS) * CLK_DIV cycles.
  - ready returns high in the cycle after the last stop-bit cycle. Back-to-back frames therefore have >= 1 extra idle-high cycle.
- Bit timer: counts 0..CLK_DIV-1 and wraps, generating a bit-end strobe at CLK_DIV-1. A bit counter tracks data and stop bits. Both clear on every state change. No counter overflows for any legal parameters.
- The calculator's reset is driven only by the internal clear strobe, never by reset_n. Calculator state is don't-care outside a frame and is always re-initialized at START.
- busy = !ready at all times.

Test Plan:
- CLK_DIV=4, data=0x55, parity_en=1, parity_odd=0 -> tx sequence per 4-cycle bit: 0, then 1,0,1,0,1,0,1,0, parity 0, stop 1. busy high exactly 44 cycles.
- Same word with parity_odd=1 -> parity bit 1. data=0x01 with even parity -> parity bit 1. data=0x00 with odd parity -> parity bit 1.
- parity_en=0, data=0xA3 -> start 0, bits 1,1,0,0,0,1,0,1, stop 1. Frame length 40 cycles, no parity slot.
- STOP_BITS=2, valid held high continuously with two words -> tx high for 8 cycles plus exactly 1 idle cycle between frames. Second start bit begins 1 cycle after ready reasserts.
- Change data/parity_odd and pulse valid mid-frame -> frame bits unchanged, ready stays 0, nothing transmitted later from the ignored request.
- Assert reset_n low during the DATA state (bit 3) -> tx=1 and ready=1 asynchronously. After release, a new 0x0F even-parity frame is transmitted correctly with parity 0.
